uart_frame_parser: RTL and testbench

Byte-level frame parser placed directly downstream of the UART receiver. It consumes the receiver's byte-complete strobe and received byte. It searches for a two-byte header, reads a length byte, streams the payload bytes out with an index, and checks an 8-bit additive checksum. It reports one ok or error pulse per frame to the command/register layer above it.

---
 rtl/uart_frame_parser.sv | 155 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: header search, LEN, indexed payload stream, additive checksum.
// Optional inter-byte timeout abort is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter int          MAX_LEN     = 16,
    parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] out_index,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    typedef enum logic [2:0] {IDLE, HDR1, LEN, DATA, CHK} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d, cur;
    logic       rx_done_q;
    logic [7:0] sum_q, sum_d;
    logic [7:0] count_q, count_d;
    logic [7:0] len_q, len_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] out_index_q, out_index_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       accept;

    assign accept = rx_done && !rx_done_q;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [19:0] tmo_q, tmo_d;
    logic        tmo_hit;
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TIMEOUT_CYC - 20'd1);

    always_ff @(posedge clk) begin
        if (!rstn) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        cur         = state_q;
        sum_d       = sum_q;
        count_d     = count_q;
        len_d       = len_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
`ifdef UART_FRAME_TIMEOUT_EN
        tmo_d = (accept || state_q == IDLE) ? 20'd0 : tmo_q + 20'd1;
        // Timeout wins; a byte landing on the same cycle is parsed as if in IDLE.
        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            cur     = IDLE;
            state_d = IDLE;
            tmo_d   = '0;
        end
`endif
        if (accept) begin
            case (cur)
                IDLE: if (rx_data == HEAD0) state_d = HDR1;
                HDR1: begin
                    if (rx_data == HEAD1)      state_d = LEN;
                    else if (rx_data != HEAD0) state_d = IDLE;
                end
                LEN: begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = IDLE;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        count_d = 8'd0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    out_valid_d = 1'b1;
                    out_data_d  = rx_data;
                    out_index_d = count_q;
                    sum_d       = sum_q + rx_data;
                    count_d     = count_q + 8'd1;
                    if (count_d == len_q) state_d = CHK;
                end
                CHK: begin
                    if (rx_data == sum_q) begin
                        ok_d   = 1'b1;
                        code_d = 2'd0;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // rx_done_q resets high so a level held through reset is not seen as a new byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rx_done_q   <= 1'b1;
            sum_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            rx_done_q   <= rx_done;
            sum_q       <= sum_d;
            count_q     <= count_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign frame_len = len_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; a negedge monitor logs strobes and pulses for the scenario tasks.
module tb_uart_frame_parser;
    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data, out_index, frame_len;
    logic       frame_ok, frame_err;
    logic [1:0] err_code;

    int tests_run = 0;
    int fails     = 0;

    uart_frame_parser #(.TIMEOUT_CYC(20'd100)) dut (
        .clk(clk), .rstn(rstn), .rx_done(rx_done), .rx_data(rx_data),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .frame_len(frame_len), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] v_data[$];
    logic [7:0] v_idx[$];
    int         ok_tot = 0, err_tot = 0, err_cyc = 0;
    logic [1:0] last_code = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            v_data.push_back(out_data);
            v_idx.push_back(out_index);
        end
        if (frame_ok) ok_tot <= ok_tot + 1;
        if (frame_err) begin
            err_tot   <= err_tot + 1;
            last_code <= err_code;
            err_cyc   <= cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_done = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int hold);
        foreach (s[i]) send_byte(s[i], hold);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int ok0, v0;
        rstn = 1'b0; rx_done = 1'b1; rx_data = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests_run++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rst_pulses: got ok=%b err=%b want 0 0", frame_ok, frame_err); end
        tests_run++; if ({out_data, out_index, frame_len} !== 24'h0) begin fails++; $display("FAIL rst_regs: got %h want 000000", {out_data, out_index, frame_len}); end
        tests_run++; if (err_code !== 2'd0) begin fails++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
        // rx_done still high (data 55) across reset release must not be accepted
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_done = 1'b0;
        ok0 = ok_tot; v0 = v_data.size();
        send_seq('{8'hAA, 8'h01, 8'h05, 8'h06}, 1);
        tests_run++; if (ok_tot - ok0 !== 0 || v_data.size() - v0 !== 0) begin fails++; $display("FAIL rst_release_accept: got ok=%0d strobes=%0d want 0 0", ok_tot - ok0, v_data.size() - v0); end
    endtask

    task automatic test_good_frame;
        int v0 = v_data.size();
        send_seq('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33}, 1);
        @(posedge clk); #1;
        rx_data = 8'h69; rx_done = 1'b1;
        @(negedge clk);
        tests_run++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL good_ok_early: got %b want 0", frame_ok); end
        @(negedge clk);
        tests_run++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL good_ok_latency: got %b want 1", frame_ok); end
        rx_done = 1'b0;
        @(negedge clk);
        tests_run++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL good_ok_width: got %b want 0", frame_ok); end
        tests_run++; if (v_data.size() - v0 !== 3) begin fails++; $display("FAIL good_strobes: got %0d want 3", v_data.size() - v0); end
        else begin
            tests_run++; if ({v_data[v0], v_idx[v0], v_data[v0+1], v_idx[v0+1], v_data[v0+2], v_idx[v0+2]} !== 48'h1100_2201_3302) begin
                fails++; $display("FAIL good_payload: got %h want 110022013302", {v_data[v0], v_idx[v0], v_data[v0+1], v_idx[v0+1], v_data[v0+2], v_idx[v0+2]}); end
        end
        tests_run++; if (frame_len !== 8'd3) begin fails++; $display("FAIL good_frame_len: got %0d want 3", frame_len); end
        tests_run++; if (err_code !== 2'd0) begin fails++; $display("FAIL good_err_code: got %0d want 0", err_code); end
    endtask

    task automatic test_bad_checksum;
        int ok0 = ok_tot, e0 = err_tot, v0 = v_data.size();
        send_seq('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A}, 1);
        tests_run++; if (v_data.size() - v0 !== 3) begin fails++; $display("FAIL badsum_strobes: got %0d want 3", v_data.size() - v0); end
        tests_run++; if (err_tot - e0 !== 1 || ok_tot - ok0 !== 0) begin fails++; $display("FAIL badsum_pulses: got err=%0d ok=%0d want 1 0", err_tot - e0, ok_tot - ok0); end
        tests_run++; if (last_code !== 2'd2 || err_code !== 2'd2) begin fails++; $display("FAIL badsum_code: got %0d/%0d want 2", last_code, err_code); end
    endtask

    task automatic test_bad_length;
        int e0 = err_tot, v0 = v_data.size();
        send_seq('{8'h55, 8'hAA, 8'h00}, 1);
        tests_run++; if (err_tot - e0 !== 1 || last_code !== 2'd1) begin fails++; $display("FAIL len0: got errs=%0d code=%0d want 1 1", err_tot - e0, last_code); end
        send_seq('{8'h55, 8'hAA, 8'h11}, 1);
        tests_run++; if (err_tot - e0 !== 2 || last_code !== 2'd1) begin fails++; $display("FAIL len17: got errs=%0d code=%0d want 2 1", err_tot - e0, last_code); end
        tests_run++; if (v_data.size() - v0 !== 0) begin fails++; $display("FAIL badlen_strobes: got %0d want 0", v_data.size() - v0); end
        tests_run++; if (frame_len !== 8'd3) begin fails++; $display("FAIL badlen_frame_len_held: got %0d want 3", frame_len); end
    endtask

    task automatic test_resync_wrap;
        int ok0 = ok_tot, e0 = err_tot, v0 = v_data.size();
        send_seq('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80}, 1);
        tests_run++; if (ok_tot - ok0 !== 1) begin fails++; $display("FAIL resync_ok: got %0d want 1", ok_tot - ok0); end
        send_seq('{8'h55, 8'hAA, 8'h02, 8'hFF, 8'hFF, 8'h00}, 1);
        tests_run++; if (ok_tot - ok0 !== 2) begin fails++; $display("FAIL wrap_ok: got %0d want 2", ok_tot - ok0); end
        send_seq('{8'h55, 8'hAA, 8'h02, 8'h55, 8'hAA, 8'h01}, 1);
        tests_run++; if (ok_tot - ok0 !== 3 || err_tot - e0 !== 0) begin fails++; $display("FAIL hdr_payload_ok: got ok=%0d err=%0d want 3 0", ok_tot - ok0, err_tot - e0); end
        tests_run++; if (v_data.size() - v0 !== 5) begin fails++; $display("FAIL resync_strobes: got %0d want 5", v_data.size() - v0); end
        else begin
            tests_run++; if ({v_data[v0], v_data[v0+3], v_idx[v0+3], v_data[v0+4], v_idx[v0+4]} !== 40'h7F_5500_AA01) begin
                fails++; $display("FAIL resync_payload: got %h want 7F5500AA01", {v_data[v0], v_data[v0+3], v_idx[v0+3], v_data[v0+4], v_idx[v0+4]}); end
        end
        tests_run++; if (frame_len !== 8'd2) begin fails++; $display("FAIL resync_frame_len: got %0d want 2", frame_len); end
    endtask

    task automatic test_held_rx_done;
        int ok0 = ok_tot, v0 = v_data.size();
        send_seq('{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06}, 3);
        tests_run++; if (ok_tot - ok0 !== 1 || v_data.size() - v0 !== 1) begin fails++; $display("FAIL held_rx_done: got ok=%0d strobes=%0d want 1 1", ok_tot - ok0, v_data.size() - v0); end
    endtask

    task automatic test_reset_mid_frame;
        int ok0, e0;
        send_seq('{8'h55, 8'hAA, 8'h03, 8'h11}, 1);
        ok0 = ok_tot; e0 = err_tot;
        @(posedge clk); #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (ok_tot - ok0 !== 0 || err_tot - e0 !== 0) begin fails++; $display("FAIL midrst_pulses: got ok=%0d err=%0d want 0 0", ok_tot - ok0, err_tot - e0); end
        tests_run++; if (frame_len !== 8'd0) begin fails++; $display("FAIL midrst_frame_len: got %0d want 0", frame_len); end
        send_seq('{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06}, 1);
        tests_run++; if (ok_tot - ok0 !== 1 || err_tot - e0 !== 0) begin fails++; $display("FAIL midrst_next_ok: got ok=%0d err=%0d want 1 0", ok_tot - ok0, err_tot - e0); end
    endtask

`ifdef UART_FRAME_TIMEOUT_EN
    task automatic test_timeout;
        int e0, ok0, c0, n;
        e0 = err_tot; ok0 = ok_tot;
        send_seq('{8'h55, 8'hAA, 8'h02}, 1);
        @(posedge clk); #1 rx_data = 8'h10; rx_done = 1'b1;
        @(posedge clk); c0 = cyc; #1 rx_done = 1'b0;
        n = 0;
        while (err_tot == e0 && n < 200) begin @(negedge clk); n++; end
        tests_run++; if (err_tot - e0 !== 1 || last_code !== 2'd3) begin fails++; $display("FAIL timeout_err: got errs=%0d code=%0d want 1 3", err_tot - e0, last_code); end
        tests_run++; if (err_cyc - c0 < 98 || err_cyc - c0 > 102) begin fails++; $display("FAIL timeout_when: got %0d cycles want about 100", err_cyc - c0); end
        send_seq('{8'h55, 8'hAA, 8'h01, 8'h05, 8'h06}, 1);
        tests_run++; if (ok_tot - ok0 !== 1) begin fails++; $display("FAIL timeout_recover: got %0d want 1", ok_tot - ok0); end
    endtask
`endif

    initial begin
        rx_done = 1'b0; rx_data = 8'h00; rstn = 1'b0;
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_bad_length;
        test_resync_wrap;
        test_held_rx_done;
        test_reset_mid_frame;
`ifdef UART_FRAME_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
